// File: rtl/rm1_pkg.sv
// rm1_pkg: shared definitions for the Reed-Muller RM(1,M) encoder family.
//   k_of(m)      message length K = m + 1
//   n_of(m)      codeword length N = 2^m
//   row_mask(j)  generator column j: bit 0 = constant row, bit i = j[i-1]
//   state_e      serial-output FSM states
//   PARALLEL / SERIAL_OUT  output-mode selector values
package rm1_pkg;

  localparam int unsigned PARALLEL   = 0;
  localparam int unsigned SERIAL_OUT = 1;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  function automatic int unsigned k_of(input int unsigned m);
    return m + 1;
  endfunction

  function automatic int unsigned n_of(input int unsigned m);
    return 32'd1 << m;
  endfunction

  // Column j of the generator matrix; sized for the largest legal M (7 -> K = 8).
  function automatic logic [7:0] row_mask(input int unsigned j);
    logic [7:0] mask;
    mask = {j[6:0], 1'b1};
    return mask;
  endfunction

endpackage

// File: rtl/rm1_gen.sv
// rm1_gen: combinational RM(1,M) encoder.
//   msg  K-bit message (bit 0 = constant-row coefficient, bit i = row i coefficient)
//   cw   N-bit codeword, cw[j] = msg[0] ^ XOR_i(msg[i] & j[i-1])
module rm1_gen
  import rm1_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic [k_of(M)-1:0] msg,
  output logic [n_of(M)-1:0] cw
);

  localparam int unsigned K = k_of(M);
  localparam int unsigned N = n_of(M);

  // Each codeword bit is an independent parity over the rows selected by its column mask.
  for (genvar j = 0; j < N; j++) begin : g_bit
    localparam logic [7:0] Mask = row_mask(j);
    assign cw[j] = ^(msg & Mask[K-1:0]);
  end

endmodule

// File: rtl/rm1_stream_encoder.sv
// rm1_stream_encoder: streaming RM(1,M) encoder with valid/ready handshakes.
//   clk, reset      single clock, synchronous active-high reset
//   in_valid/ready  message handshake, in_msg is K bits
//   out_valid/ready output handshake
//   out_cw          full codeword (parallel mode), 0 in serial mode
//   out_bit         current codeword bit (serial mode), 0 in parallel mode
//   out_last        last bit of a codeword (serial), equals out_valid (parallel)
//   cw_count        completed-codeword counter, wraps at 16 bits
module rm1_stream_encoder
  import rm1_pkg::*;
#(
  parameter int unsigned M      = 4,
  parameter int unsigned SERIAL = PARALLEL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [k_of(M)-1:0]   in_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [n_of(M)-1:0]   out_cw,
  output logic                 out_bit,
  output logic                 out_last,
  output logic [15:0]          cw_count
);

  localparam int unsigned N = n_of(M);

  logic [N-1:0] gen_cw;

  rm1_gen #(
    .M(M)
  ) u_gen (
    .msg(in_msg),
    .cw (gen_cw)
  );

  if (SERIAL == SERIAL_OUT) begin : g_serial
    localparam logic [M-1:0] IdxPenult = M'(N - 2);

    state_e       state_q;
    logic [M-1:0] idx_q;
    logic [N-1:0] sr_q;
    logic         valid_q;
    logic         last_q;
    logic [15:0]  cnt_q;

    // Accept while idle, or on the final-bit transfer so codewords stream without a gap.
    assign in_ready  = (state_q == StIdle) | (last_q & out_ready);
    assign out_valid = valid_q;
    assign out_bit   = sr_q[0];
    assign out_last  = last_q;
    assign out_cw    = '0;
    assign cw_count  = cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StIdle;
        idx_q   <= '0;
        sr_q    <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (in_valid) begin
              sr_q    <= gen_cw;
              idx_q   <= '0;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
              state_q <= StSend;
            end
          end
          StSend: begin
            if (out_ready) begin
              if (last_q) begin
                cnt_q <= cnt_q + 16'd1;
                idx_q <= '0;
                if (in_valid) begin
                  sr_q   <= gen_cw;
                  last_q <= 1'b0;
                end else begin
                  sr_q    <= '0;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  state_q <= StIdle;
                end
              end else begin
                // Shift so the bit being presented is always sr_q[0].
                sr_q   <= sr_q >> 1;
                idx_q  <= idx_q + 1'b1;
                last_q <= (idx_q == IdxPenult);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end else begin : g_parallel
    logic [N-1:0] cw_q;
    logic         valid_q;
    logic [15:0]  cnt_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_cw    = cw_q;
    assign out_bit   = 1'b0;
    assign out_last  = valid_q;
    assign cw_count  = cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cw_q    <= '0;
        valid_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        if (in_valid && in_ready) begin
          cw_q    <= gen_cw;
          valid_q <= 1'b1;
        end else if (out_ready) begin
          valid_q <= 1'b0;
        end
        if (valid_q && out_ready) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

endmodule
